// File: rtl/munch_vga_gen.sv
// Munching-squares video generator: VGA timing plus a (x OP y) < t pattern engine.
// Optional MUNCH_COLOR_CYCLE_EN derives lit-pixel colour from t instead of white.
module munch_vga_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned T_BITS     = 10,
  parameter int unsigned COLOR_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [1:0]            mode,
  input  logic [2:0]            speed,
  input  logic                  pause,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b,
  output logic                  frame_tick
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);
  localparam int unsigned XW      = (H_W > T_BITS) ? H_W : T_BITS;
  localparam int unsigned YW      = (V_W > T_BITS) ? V_W : T_BITS;

  logic [H_W-1:0]        r_hcnt;
  logic [V_W-1:0]        r_vcnt;
  logic [T_BITS-1:0]     r_t;
  logic [1:0]            r_mode_q;
  logic                  r_hsync;
  logic                  r_vsync;
  logic                  r_de;
  logic [COLOR_BITS-1:0] r_red;
  logic [COLOR_BITS-1:0] r_grn;
  logic [COLOR_BITS-1:0] r_blu;
  logic                  r_frame_tick;

  logic                  w_h_last;
  logic                  w_v_last;
  logic                  w_frame_end;
  logic                  w_active;
  logic                  w_hs_n;
  logic                  w_vs_n;
  logic [XW-1:0]         w_hx;
  logic [YW-1:0]         w_vy;
  logic [T_BITS-1:0]     w_x;
  logic [T_BITS-1:0]     w_y;
  logic [T_BITS-1:0]     w_v;
  logic                  w_lit;
  logic [COLOR_BITS-1:0] w_cr;
  logic [COLOR_BITS-1:0] w_cg;
  logic [COLOR_BITS-1:0] w_cb;

  // Counter wrap and region decode from the current position.
  assign w_h_last    = (32'(r_hcnt) == H_TOTAL - 1);
  assign w_v_last    = (32'(r_vcnt) == V_TOTAL - 1);
  assign w_frame_end = w_h_last && w_v_last;
  assign w_active    = (32'(r_hcnt) < H_ACTIVE) && (32'(r_vcnt) < V_ACTIVE);
  assign w_hs_n      = !((32'(r_hcnt) >= H_ACTIVE + H_FP) &&
                         (32'(r_hcnt) <  H_ACTIVE + H_FP + H_SYNC));
  assign w_vs_n      = !((32'(r_vcnt) >= V_ACTIVE + V_FP) &&
                         (32'(r_vcnt) <  V_ACTIVE + V_FP + V_SYNC));

  // Zero-extend first so counters narrower than T_BITS still slice cleanly.
  assign w_hx = XW'(r_hcnt);
  assign w_vy = YW'(r_vcnt);
  assign w_x  = w_hx[T_BITS-1:0];
  assign w_y  = w_vy[T_BITS-1:0];

  always_comb begin
    w_v = '0;
    case (r_mode_q)
      2'd0:    w_v = w_x ^ w_y;
      2'd1:    w_v = w_x & w_y;
      2'd2:    w_v = w_x | w_y;
      default: w_v = ~(w_x ^ w_y);
    endcase
  end

  assign w_lit = w_active && (w_v < r_t);

`ifdef MUNCH_COLOR_CYCLE_EN
  // An all-zero colour would be indistinguishable from dark, so force white.
  always_comb begin
    w_cr = r_t[COLOR_BITS-1:0];
    w_cg = r_t[2*COLOR_BITS-1:COLOR_BITS];
    w_cb = ~r_t[COLOR_BITS-1:0];
    if ((w_cr == '0) && (w_cg == '0) && (w_cb == '0)) begin
      w_cr = '1;
      w_cg = '1;
      w_cb = '1;
    end
  end
`else
  assign w_cr = '1;
  assign w_cg = '1;
  assign w_cb = '1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt       <= '0;
      r_vcnt       <= '0;
      r_t          <= '0;
      r_mode_q     <= '0;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_de         <= 1'b0;
      r_red        <= '0;
      r_grn        <= '0;
      r_blu        <= '0;
      r_frame_tick <= 1'b0;
    end else if (ena) begin
      r_hcnt <= w_h_last ? '0 : r_hcnt + H_W'(1);
      if (w_h_last) begin
        r_vcnt <= w_v_last ? '0 : r_vcnt + V_W'(1);
      end
      // Mode and t only change between frames so a frame never tears.
      if (w_frame_end) begin
        r_mode_q <= mode;
        if (!pause) begin
          r_t <= r_t + T_BITS'(speed) + T_BITS'(1);
        end
      end
      r_hsync      <= w_hs_n;
      r_vsync      <= w_vs_n;
      r_de         <= w_active;
      r_red        <= w_lit ? w_cr : '0;
      r_grn        <= w_lit ? w_cg : '0;
      r_blu        <= w_lit ? w_cb : '0;
      r_frame_tick <= w_frame_end;
    end
  end

  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign de         = r_de;
  assign r          = r_red;
  assign g          = r_grn;
  assign b          = r_blu;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_munch_vga_gen.sv
// Directed vector bench for munch_vga_gen on a shrunk 16x10 raster (frame = 160 clocks, T_BITS=4).
module tb_munch_vga_gen;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [1:0] mode;
  logic [2:0] speed;
  logic       pause;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [1:0] r;
  logic [1:0] g;
  logic [1:0] b;
  logic       frame_tick;

  // H: 8 active, fp 2, sync 3 (hcnt 10..12), bp 3 -> 16. V: 6 active, fp 1, sync 2 (vcnt 7..8), bp 1 -> 10.
  munch_vga_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .T_BITS(4), .COLOR_BITS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .speed(speed), .pause(pause),
    .hsync(hsync), .vsync(vsync), .de(de), .r(r), .g(g), .b(b), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic [2:0] speed;
    logic       pause;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_err;
  int   cyc;

  // Expected bundle packed as {hsync, vsync, de, r, g, b, frame_tick}.
  function automatic logic [9:0] e(logic hs, logic vs, logic d, logic [5:0] rgb, logic ft);
    return {hs, vs, d, rgb, ft};
  endfunction

  task automatic add(int c, logic [1:0] m, logic [2:0] s, logic p, logic [9:0] x);
    vec_t v;
    v.cyc = c; v.mode = m; v.speed = s; v.pause = p; v.exp = x;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(string name, logic [9:0] x);
    logic [9:0] act;
    act = {hsync, vsync, de, r, g, b, frame_tick};
    n_vec++;
    if (act !== x) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %b, want %b (hs,vs,de,rgb,ft)", name, cyc, act, x);
    end
  endtask

  task automatic run_to(int c);
    if (c <= cyc) begin
      n_err++;
      $display("FAIL run_to: target %0d not after %0d", c, cyc);
    end
    while (cyc < c) step();
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0; ena = 1'b1; mode = 2'd0; speed = 3'd0; pause = 1'b0;

    // Cycle n after release shows pixel p = n-1; t per frame: 0,1,5,5(paused),13,0(wrap).
    add(  1, 0, 0, 0, e(1,1,1,6'h00,0));  // first pixel (0,0) active
    add(  6, 0, 0, 0, e(1,1,1,6'h00,0));  // t=0: nothing lit
    add(  9, 0, 0, 0, e(1,1,0,6'h00,0));  // hcnt=8 front porch
    add( 11, 0, 0, 0, e(0,1,0,6'h00,0));  // hsync starts at hcnt=10
    add( 13, 0, 0, 0, e(0,1,0,6'h00,0));
    add( 14, 0, 0, 0, e(1,1,0,6'h00,0));  // hsync 3 wide
    add(113, 0, 0, 0, e(1,0,0,6'h00,0));  // vsync starts line 7
    add(144, 0, 0, 0, e(1,0,0,6'h00,0));  // last clock of line 8
    add(145, 0, 0, 0, e(1,1,0,6'h00,0));  // vsync ends line 9
    add(160, 0, 0, 0, e(1,1,0,6'h00,1));  // frame tick on last pixel
    add(161, 0, 0, 0, e(1,1,1,6'h3f,0));  // frame1 XOR t=1: (0,0) lit, tick gone
    add(194, 1, 3, 0, e(1,1,1,6'h00,0));  // mode->AND mid-frame; (1,2) still XOR=3 dark
    add(230, 1, 3, 0, e(1,1,1,6'h00,0));  // (5,4) dark
    add(246, 1, 3, 0, e(1,1,1,6'h3f,0));  // (5,5) lit
    add(320, 1, 3, 0, e(1,1,0,6'h00,1));  // second frame tick, 160 apart
    add(354, 2, 3, 1, e(1,1,1,6'h3f,0));  // frame2 AND t=5: (1,2) lit
    add(407, 2, 3, 1, e(1,1,1,6'h3f,0));  // (6,5) AND=4 lit (OR would be dark)
    add(408, 2, 3, 1, e(1,1,1,6'h00,0));  // (7,5) AND=5 == t dark
    add(485, 2, 3, 1, e(1,1,1,6'h3f,0));  // frame3 OR, t held at 5: (4,0) lit
    add(486, 3, 7, 0, e(1,1,1,6'h00,0));  // (5,0) dark proves pause held t
    add(640, 3, 7, 0, e(1,1,0,6'h00,1));
    add(641, 3, 7, 0, e(1,1,1,6'h00,0));  // frame4 XNOR t=13: (0,0)=15 dark
    add(643, 3, 2, 0, e(1,1,1,6'h00,0));  // (2,0)=13 dark (boundary)
    add(644, 3, 2, 0, e(1,1,1,6'h3f,0));  // (3,0)=12 lit
    add(801, 3, 2, 0, e(1,1,1,6'h00,0));  // t=13+3 wraps to 0
    add(804, 3, 2, 0, e(1,1,1,6'h00,0));  // (3,0) now dark

    // Reset held with ena high.
    repeat (3) step();
    chk("reset_hold", e(1,1,0,6'h00,0));
    rst_n = 1'b1;
    cyc = 0;

    foreach (tbl[i]) begin
      mode  = tbl[i].mode;
      speed = tbl[i].speed;
      pause = tbl[i].pause;
      run_to(tbl[i].cyc);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Freeze inside the hsync pulse, then resume on the same count.
    run_to(811);
    chk("pre_freeze", e(0,1,0,6'h00,0));
    ena = 1'b0;
    repeat (100) begin
      @(posedge clk);
      #1;
    end
    chk("frozen", e(0,1,0,6'h00,0));
    ena = 1'b1;
    step(); step();
    chk("resume_hs_low", e(0,1,0,6'h00,0));
    step();
    chk("resume_hs_end", e(1,1,0,6'h00,0));
    repeat (3) step();
    chk("resume_line1", e(1,1,1,6'h00,0));
    repeat (10) step();
    chk("pre_reset", e(0,1,0,6'h00,0));

    // Asynchronous reset mid-frame: outputs change before any clock edge.
    rst_n = 1'b0;
    #1;
    chk("async_reset", e(1,1,0,6'h00,0));
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("post_reset_p0", e(1,1,1,6'h00,0));
    repeat (10) step();
    chk("post_reset_hs", e(0,1,0,6'h00,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
